// File: rtl/quad_pkg.sv
// ---------------------------------------------------------------------------
// quad_pkg
// Shared definitions for the multi-channel quadrature decoder:
//   - default widths/timing constants, also consumed by the register map
//   - decode result encoding (HOLD / UP / DOWN / ILLEGAL)
//   - per-channel prime/run state encoding (visible as r_state in each channel)
//   - quad_decode(): classifies one filtered A/B transition
// ---------------------------------------------------------------------------
package quad_pkg;

  localparam int QUAD_CNT_W       = 32;
  localparam int QUAD_SYNC_STAGES = 2;
  localparam int QUAD_FILT_CYCLES = 4;

  typedef enum logic [1:0] {
    DEC_HOLD    = 2'd0,
    DEC_UP      = 2'd1,
    DEC_DOWN    = 2'd2,
    DEC_ILLEGAL = 2'd3
  } quad_dec_e;

  typedef enum logic {
    ST_PRIME = 1'b0,
    ST_RUN   = 1'b1
  } quad_state_e;

  // Single-bit change is a step whose direction is curA ^ prevB; this makes
  // 00->10->11->01->00 (A leading B) count up. Both bits changing is illegal.
  function automatic quad_dec_e quad_decode(input logic cur_a, input logic cur_b,
                                            input logic prev_a, input logic prev_b);
    logic chg_a;
    logic chg_b;
    quad_dec_e res;
    chg_a = cur_a ^ prev_a;
    chg_b = cur_b ^ prev_b;
    res   = DEC_HOLD;
    if (chg_a && chg_b) begin
      res = DEC_ILLEGAL;
    end else if (chg_a || chg_b) begin
      res = (cur_a ^ prev_b) ? DEC_UP : DEC_DOWN;
    end
    return res;
  endfunction

endpackage

// File: rtl/quad_channel.sv
// ---------------------------------------------------------------------------
// quad_channel
// One quadrature channel: synchroniser -> glitch filter -> prime -> x4 decode
// -> wrapping signed position counter, sticky error, direction, step pulse.
// Optional index capture when QUAD_INDEX_EN is defined.
//
// Ports
//   clk, reset      system clock, synchronous active-high reset
//   i_a, i_b        raw encoder phases (asynchronous)
//   i_clear         synchronous count clear (wins over a coincident step)
//   i_err_clr       clear of sticky error (loses to a coincident illegal edge)
//   i_index         raw index pulse (asynchronous)        [QUAD_INDEX_EN]
//   o_idx_count     count captured on filtered index rise  [QUAD_INDEX_EN]
//   o_idx_valid     sticky capture flag, cleared by clear  [QUAD_INDEX_EN]
//   o_count         position count, two's complement, wraps
//   o_dir           direction of last accepted step (1 = up)
//   o_step          one-cycle pulse per accepted step
//   o_err           sticky illegal-transition flag
//
// Handshake: none. Inputs are level-sampled every cycle; o_step is a strobe
// valid for exactly one cycle, coincident with the o_count update.
// ---------------------------------------------------------------------------
module quad_channel
  import quad_pkg::*;
#(
  parameter int CNT_W       = QUAD_CNT_W,
  parameter int SYNC_STAGES = QUAD_SYNC_STAGES,
  parameter int FILT_CYCLES = QUAD_FILT_CYCLES
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_a,
  input  logic             i_b,
  input  logic             i_clear,
  input  logic             i_err_clr,
`ifdef QUAD_INDEX_EN
  input  logic             i_index,
  output logic [CNT_W-1:0] o_idx_count,
  output logic             o_idx_valid,
`endif
  output logic [CNT_W-1:0] o_count,
  output logic             o_dir,
  output logic             o_step,
  output logic             o_err
);

  // Signal lanes: bit 0 = A, bit 1 = B, bit 2 = index (when present).
`ifdef QUAD_INDEX_EN
  localparam int NSIG = 3;
`else
  localparam int NSIG = 2;
`endif
  localparam int FW        = $clog2(FILT_CYCLES + 1);
  localparam int PRIME_CYC = SYNC_STAGES + FILT_CYCLES;
  localparam int PW        = $clog2(PRIME_CYC + 1);

  logic [NSIG-1:0] w_raw;
`ifdef QUAD_INDEX_EN
  assign w_raw = {i_index, i_b, i_a};
`else
  assign w_raw = {i_b, i_a};
`endif

  // ---------------- synchroniser (no logic ahead of stage 0) ----------------
  logic [NSIG-1:0] r_sync [SYNC_STAGES];
  logic [NSIG-1:0] w_sync;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= '0;
    end else begin
      r_sync[0] <= w_raw;
      for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
    end
  end

  assign w_sync = r_sync[SYNC_STAGES-1];

  // ---------------- glitch filter ----------------
  // r_fcnt counts consecutive cycles the synchronised level has been stable
  // (saturating at FILT_CYCLES); the filtered level follows once it saturates.
  logic [NSIG-1:0] r_last;
  logic [NSIG-1:0] r_filt;
  logic [FW-1:0]   r_fcnt     [NSIG];
  logic [FW-1:0]   w_fcnt_nxt [NSIG];

  always_comb begin
    for (int s = 0; s < NSIG; s++) begin
      w_fcnt_nxt[s] = r_fcnt[s];
      if (w_sync[s] != r_last[s]) begin
        w_fcnt_nxt[s] = FW'(1);
      end else if (r_fcnt[s] != FW'(FILT_CYCLES)) begin
        w_fcnt_nxt[s] = r_fcnt[s] + FW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_last <= '0;
      r_filt <= '0;
      for (int s = 0; s < NSIG; s++) r_fcnt[s] <= '0;
    end else begin
      r_last <= w_sync;
      for (int s = 0; s < NSIG; s++) begin
        r_fcnt[s] <= w_fcnt_nxt[s];
        if (w_fcnt_nxt[s] == FW'(FILT_CYCLES)) r_filt[s] <= w_sync[s];
      end
    end
  end

  // ---------------- prime FSM ----------------
  // Filtered levels are meaningless until the pipeline has filled; wait
  // PRIME_CYC cycles, then take them as the reference without decoding.
  quad_state_e     r_state;
  quad_state_e     w_state_nxt;
  logic [PW-1:0]   r_pcnt;
  logic            w_load;
  quad_dec_e       w_dec;
  logic [NSIG-1:0] r_ref;

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_dec       = DEC_HOLD;
    case (r_state)
      ST_PRIME: begin
        if (r_pcnt == PW'(PRIME_CYC)) begin
          w_state_nxt = ST_RUN;
          w_load      = 1'b1;
        end
      end
      ST_RUN: begin
        w_dec = quad_decode(r_filt[0], r_filt[1], r_ref[0], r_ref[1]);
      end
      default: w_state_nxt = ST_PRIME;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_PRIME;
      r_pcnt  <= '0;
      r_ref   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == ST_PRIME && !w_load) r_pcnt <= r_pcnt + PW'(1);
      if (w_load || r_state == ST_RUN) r_ref <= r_filt;
    end
  end

  // ---------------- counter / flags ----------------
  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] w_count_nxt;
  logic             r_dir;
  logic             r_step;
  logic             r_err;
  logic             w_is_step;

  assign w_is_step = (w_dec == DEC_UP) || (w_dec == DEC_DOWN);

  always_comb begin
    w_count_nxt = r_count;
    if (i_clear) begin
      w_count_nxt = '0;
    end else if (w_dec == DEC_UP) begin
      w_count_nxt = r_count + CNT_W'(1);
    end else if (w_dec == DEC_DOWN) begin
      w_count_nxt = r_count - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= '0;
      r_dir   <= 1'b0;
      r_step  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_count <= w_count_nxt;
      r_step  <= w_is_step;
      if (w_is_step) r_dir <= (w_dec == DEC_UP);
      if (w_dec == DEC_ILLEGAL) begin
        r_err <= 1'b1;
      end else if (i_err_clr) begin
        r_err <= 1'b0;
      end
    end
  end

  assign o_count = r_count;
  assign o_dir   = r_dir;
  assign o_step  = r_step;
  assign o_err   = r_err;

`ifdef QUAD_INDEX_EN
  // Capture the post-update count, so a coincident clear captures zero.
  logic             w_idx_rise;
  logic [CNT_W-1:0] r_idx_count;
  logic             r_idx_valid;

  assign w_idx_rise = (r_state == ST_RUN) && r_filt[2] && !r_ref[2];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_idx_count <= '0;
      r_idx_valid <= 1'b0;
    end else begin
      if (w_idx_rise) r_idx_count <= w_count_nxt;
      if (w_idx_rise) begin
        r_idx_valid <= 1'b1;
      end else if (i_clear) begin
        r_idx_valid <= 1'b0;
      end
    end
  end

  assign o_idx_count = r_idx_count;
  assign o_idx_valid = r_idx_valid;
`endif

endmodule

// File: rtl/quad_decoder_mc.sv
// ---------------------------------------------------------------------------
// quad_decoder_mc
// Multi-channel quadrature decoder: NUM_CH independent quad_channel instances
// with flat port packing (channel n occupies count[n*CNT_W +: CNT_W]).
// Optional feature macro: QUAD_INDEX_EN (index input, idx_count/idx_valid).
//
// Ports
//   clk, reset   system clock, synchronous active-high reset
//   quadA/quadB  raw encoder phases per channel (asynchronous)
//   clear        per-channel synchronous count clear
//   err_clr      per-channel clear of sticky err
//   count        packed position counts
//   dir          direction of last accepted step per channel (1 = up)
//   step         one-cycle pulse per accepted step
//   err          sticky illegal-transition flag
//   index        raw index per channel                 [QUAD_INDEX_EN]
//   idx_count    packed counts captured at index rise  [QUAD_INDEX_EN]
//   idx_valid    sticky capture flag per channel       [QUAD_INDEX_EN]
// Per-channel prime state is visible as g_ch[n].u_ch.r_state.
// ---------------------------------------------------------------------------
module quad_decoder_mc
  import quad_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int CNT_W       = QUAD_CNT_W,
  parameter int SYNC_STAGES = QUAD_SYNC_STAGES,
  parameter int FILT_CYCLES = QUAD_FILT_CYCLES
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_CH-1:0]       quadA,
  input  logic [NUM_CH-1:0]       quadB,
  input  logic [NUM_CH-1:0]       clear,
  input  logic [NUM_CH-1:0]       err_clr,
`ifdef QUAD_INDEX_EN
  input  logic [NUM_CH-1:0]       index,
  output logic [NUM_CH*CNT_W-1:0] idx_count,
  output logic [NUM_CH-1:0]       idx_valid,
`endif
  output logic [NUM_CH*CNT_W-1:0] count,
  output logic [NUM_CH-1:0]       dir,
  output logic [NUM_CH-1:0]       step,
  output logic [NUM_CH-1:0]       err
);

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    quad_channel #(
      .CNT_W       (CNT_W),
      .SYNC_STAGES (SYNC_STAGES),
      .FILT_CYCLES (FILT_CYCLES)
    ) u_ch (
      .clk         (clk),
      .reset       (reset),
      .i_a         (quadA[g]),
      .i_b         (quadB[g]),
      .i_clear     (clear[g]),
      .i_err_clr   (err_clr[g]),
`ifdef QUAD_INDEX_EN
      .i_index     (index[g]),
      .o_idx_count (idx_count[g*CNT_W +: CNT_W]),
      .o_idx_valid (idx_valid[g]),
`endif
      .o_count     (count[g*CNT_W +: CNT_W]),
      .o_dir       (dir[g]),
      .o_step      (step[g]),
      .o_err       (err[g])
    );
  end

endmodule

// File: tb/tb_quad_decoder_mc.sv
// ---------------------------------------------------------------------------
// tb_quad_decoder_mc
// Bench for quad_decoder_mc (default build and QUAD_INDEX_EN build).
// A second narrow instance (CNT_W=4) exercises counter wrap in a few steps.
// Reference model: position tracked as a Gray-code index delta (+1/-1/illegal)
// per driven A/B level, independent of the decoder's internal pipeline.
// ---------------------------------------------------------------------------
module tb_quad_decoder_mc;
  localparam int NUM_CH = 4;
  localparam int CNT_W  = 32;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [NUM_CH-1:0]       quadA, quadB, clear, err_clr;
  logic [NUM_CH*CNT_W-1:0] count;
  logic [NUM_CH-1:0]       dir, step, err;
  logic [0:0] s_a, s_b, s_clear, s_errclr, s_dir, s_step, s_err;
  logic [3:0] s_count;
`ifdef QUAD_INDEX_EN
  logic [NUM_CH-1:0]       index;
  logic [NUM_CH*CNT_W-1:0] idx_count;
  logic [NUM_CH-1:0]       idx_valid;
  logic [0:0] s_index, s_idx_valid;
  logic [3:0] s_idx_count;
`endif

  quad_decoder_mc #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .SYNC_STAGES(2), .FILT_CYCLES(4)) dut (
    .clk(clk), .reset(reset), .quadA(quadA), .quadB(quadB), .clear(clear), .err_clr(err_clr),
`ifdef QUAD_INDEX_EN
    .index(index), .idx_count(idx_count), .idx_valid(idx_valid),
`endif
    .count(count), .dir(dir), .step(step), .err(err)
  );

  quad_decoder_mc #(.NUM_CH(1), .CNT_W(4), .SYNC_STAGES(2), .FILT_CYCLES(4)) u_small (
    .clk(clk), .reset(reset), .quadA(s_a), .quadB(s_b), .clear(s_clear), .err_clr(s_errclr),
`ifdef QUAD_INDEX_EN
    .index(s_index), .idx_count(s_idx_count), .idx_valid(s_idx_valid),
`endif
    .count(s_count), .dir(s_dir), .step(s_step), .err(s_err)
  );

  // ---------------- bookkeeping ----------------
  int checks = 0;
  int errors = 0;
  logic [CNT_W-1:0] exp_q[$];
  int step_cnt [NUM_CH];

  logic [31:0] m_pos   [NUM_CH];
  logic [1:0]  m_ab    [NUM_CH];
  logic        m_dir   [NUM_CH];
  logic        m_err   [NUM_CH];
  int          m_steps [NUM_CH];
  logic [3:0]  s_pos;
  logic [1:0]  s_ab;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] cnt_of(input int ch);
    return count[ch*CNT_W +: CNT_W];
  endfunction

  // Gray position of an {A,B} level: 00,10,11,01 = 0,1,2,3
  function automatic int gidx(input logic [1:0] ab);
    case (ab)
      2'b00:   return 0;
      2'b10:   return 1;
      2'b11:   return 2;
      default: return 3;
    endcase
  endfunction

  function automatic logic [1:0] gray(input int i);
    case (i % 4)
      0:       return 2'b00;
      1:       return 2'b10;
      2:       return 2'b11;
      default: return 2'b01;
    endcase
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_ab(input int ch, input logic [1:0] ab);
    int d;
    d = (gidx(ab) - gidx(m_ab[ch]) + 4) % 4;
    if (d == 1) begin
      m_pos[ch] = m_pos[ch] + 32'd1;
      m_dir[ch] = 1'b1;
      m_steps[ch]++;
      if (ch == 0) exp_q.push_back(m_pos[0]);
    end else if (d == 3) begin
      m_pos[ch] = m_pos[ch] - 32'd1;
      m_dir[ch] = 1'b0;
      m_steps[ch]++;
      if (ch == 0) exp_q.push_back(m_pos[0]);
    end else if (d == 2) begin
      m_err[ch] = 1'b1;
    end
    m_ab[ch]  = ab;
    quadA[ch] = ab[1];
    quadB[ch] = ab[0];
  endtask

  task automatic s_set(input logic [1:0] ab);
    int d;
    d = (gidx(ab) - gidx(s_ab) + 4) % 4;
    if (d == 1) s_pos = s_pos + 4'd1;
    else if (d == 3) s_pos = s_pos - 4'd1;
    s_ab = ab;
    s_a  = ab[1];
    s_b  = ab[0];
  endtask

  task automatic pulse_clear(input int ch);
    clear[ch] = 1'b1;
    tick(1);
    clear[ch] = 1'b0;
    m_pos[ch] = '0;
  endtask

  task automatic check_ch(input int ch, input string tag);
    chk({tag, "_count"}, cnt_of(ch), m_pos[ch]);
    chk({tag, "_dir"}, 32'(dir[ch]), 32'(m_dir[ch]));
    chk({tag, "_err"}, 32'(err[ch]), 32'(m_err[ch]));
  endtask

  task automatic model_reset();
    for (int c = 0; c < NUM_CH; c++) begin
      m_pos[c] = '0; m_dir[c] = 1'b0; m_err[c] = 1'b0;
      m_ab[c] = {quadA[c], quadB[c]};
    end
    s_pos = '0;
    s_ab  = {s_a, s_b};
    exp_q.delete();
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (!reset) begin
      for (int c = 0; c < NUM_CH; c++) if (step[c]) step_cnt[c]++;
      if (step[0]) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_step: unexpected ch0 step, count 0x%08h, expected no step", cnt_of(0));
        end else begin
          chk("sb_count", cnt_of(0), exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not reach the summary, expected completion");
    $fatal(1);
  end

  // ---------------- table ----------------
  typedef struct {
    logic [1:0]  ab;
    logic [31:0] exp_count;
    logic        exp_dir;
    logic        exp_err;
  } vec_t;
  vec_t vecs [8];

  initial begin
    int base;
    vecs[0] = '{2'b10, 32'h0000_0001, 1'b1, 1'b0};
    vecs[1] = '{2'b01, 32'h0000_0001, 1'b1, 1'b1};  // both phases flip
    vecs[2] = '{2'b11, 32'h0000_0000, 1'b0, 1'b1};
    vecs[3] = '{2'b10, 32'hFFFF_FFFF, 1'b0, 1'b1};
    vecs[4] = '{2'b00, 32'hFFFF_FFFE, 1'b0, 1'b1};
    vecs[5] = '{2'b11, 32'hFFFF_FFFE, 1'b0, 1'b1};  // both phases flip
    vecs[6] = '{2'b01, 32'hFFFF_FFFF, 1'b1, 1'b1};
    vecs[7] = '{2'b00, 32'h0000_0000, 1'b1, 1'b1};

    reset = 1'b1;
    quadA = '0; quadB = '0; clear = '0; err_clr = '0;
    s_a = '0; s_b = '0; s_clear = '0; s_errclr = '0;
`ifdef QUAD_INDEX_EN
    index = '0; s_index = '0;
`endif
    for (int c = 0; c < NUM_CH; c++) m_steps[c] = 0;
    model_reset();
    tick(4);

    // reset state
    for (int c = 0; c < NUM_CH; c++) begin
      chk("rst_count", cnt_of(c), 32'd0);
    end
    chk("rst_dir", 32'(dir), 32'd0);
    chk("rst_step", 32'(step), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
`ifdef QUAD_INDEX_EN
    chk("rst_idx_valid", 32'(idx_valid), 32'd0);
    chk("rst_idx_count0", idx_count[31:0], 32'd0);
`endif
    reset = 1'b0;
    tick(12);

    // test 1: forward x10, 10 cycles per state
    for (int r = 0; r < 10; r++)
      for (int k = 1; k <= 4; k++) begin set_ab(0, gray(k)); tick(10); end
    chk("t1_count", cnt_of(0), 32'd40);
    chk("t1_dir", 32'(dir[0]), 32'd1);
    chk("t1_steps", 32'(step_cnt[0]), 32'd40);
    chk("t1_err", 32'(err[0]), 32'd0);

    // test 2: reverse x3 from zero
    pulse_clear(0);
    tick(2);
    chk("clr_count", cnt_of(0), 32'd0);
    for (int r = 0; r < 3; r++)
      for (int k = 3; k >= 0; k--) begin set_ab(0, gray(k)); tick(10); end
    chk("t2_count", cnt_of(0), 32'hFFFF_FFF4);
    chk("t2_dir", 32'(dir[0]), 32'd0);
    for (int c = 1; c < NUM_CH; c++) chk("t2_other", cnt_of(c), 32'd0);

    // table-driven vectors on ch0
    pulse_clear(0);
    tick(2);
    for (int v = 0; v < 8; v++) begin
      set_ab(0, vecs[v].ab);
      tick(10);
      chk("tbl_count", cnt_of(0), vecs[v].exp_count);
      chk("tbl_dir", 32'(dir[0]), 32'(vecs[v].exp_dir));
      chk("tbl_err", 32'(err[0]), 32'(vecs[v].exp_err));
    end
    err_clr[0] = 1'b1; tick(1); err_clr[0] = 1'b0; m_err[0] = 1'b0;
    tick(1);
    chk("errclr", 32'(err[0]), 32'd0);

    // glitches of 2 and FILT_CYCLES-1 cycles on A: nothing accepted
    base = step_cnt[0];
    quadA[0] = 1'b1; tick(2); quadA[0] = 1'b0; tick(10);
    quadA[0] = 1'b1; tick(3); quadA[0] = 1'b0; tick(10);
    chk("glitch_steps", 32'(step_cnt[0]), 32'(base));
    chk("glitch_count", cnt_of(0), 32'd0);
    chk("glitch_err", 32'(err[0]), 32'd0);

    // illegal edge with err_clr in the same cycle: set wins
    quadA[0] = 1'b1; quadB[0] = 1'b1; m_ab[0] = 2'b11; m_err[0] = 1'b1;
    tick(6);
    err_clr[0] = 1'b1; tick(1); err_clr[0] = 1'b0;
    chk("errclr_vs_set", 32'(err[0]), 32'd1);
    chk("illegal_count", cnt_of(0), 32'd0);
    tick(3);
    err_clr[0] = 1'b1; tick(1); err_clr[0] = 1'b0; m_err[0] = 1'b0;
    chk("errclr_after", 32'(err[0]), 32'd0);
    set_ab(0, 2'b01); tick(10);
    set_ab(0, 2'b00); tick(10);
    chk("post_illegal_count", cnt_of(0), 32'd2);

    // clear coincident with a step: count 0, step/dir still reported
    base = step_cnt[0];
    quadA[0] = 1'b1; m_ab[0] = 2'b10; m_dir[0] = 1'b1; m_steps[0]++; m_pos[0] = '0;
    exp_q.push_back(32'd0);
    tick(6);
    clear[0] = 1'b1; tick(1); clear[0] = 1'b0;
    chk("clr_step_count", cnt_of(0), 32'd0);
    chk("clr_step_pulse", 32'(step[0]), 32'd1);
    chk("clr_step_dir", 32'(dir[0]), 32'd1);
    tick(4);
    chk("clr_step_seen", 32'(step_cnt[0]), 32'(base + 1));

    // wrap on the 4-bit instance: 0 -1 -> 0xF, up to +7, +1 -> -8, -1 -> +7
    s_set(gray(3)); tick(10);
    chk("wrap_neg", 32'(s_count), 32'h0000_000F);
    for (int k = 0; k < 8; k++) begin s_set(gray(gidx(s_ab) + 1)); tick(8); end
    chk("wrap_max", 32'(s_count), 32'h0000_0007);
    s_set(gray(gidx(s_ab) + 1)); tick(10);
    chk("wrap_up", 32'(s_count), 32'h0000_0008);
    chk("wrap_up_model", 32'(s_count), 32'(s_pos));
    s_set(gray(gidx(s_ab) + 3)); tick(10);
    chk("wrap_down", 32'(s_count), 32'h0000_0007);
    chk("wrap_dir", 32'(s_dir), 32'd0);

    // randomized motion on all channels against the model
    for (int it = 0; it < 60; it++) begin
      for (int c = 0; c < NUM_CH; c++) begin
        int r;
        r = $urandom_range(0, 9);
        if (r < 4) set_ab(c, gray(gidx(m_ab[c]) + 1));
        else if (r < 8) set_ab(c, gray(gidx(m_ab[c]) + 3));
        else if (r == 8) set_ab(c, m_ab[c] ^ 2'b11);
      end
      tick($urandom_range(8, 12));
      for (int c = 0; c < NUM_CH; c++) begin
        check_ch(c, "rnd");
        if (m_err[c] && $urandom_range(0, 1) == 1) begin
          err_clr[c] = 1'b1; tick(1); err_clr[c] = 1'b0; m_err[c] = 1'b0;
        end
      end
    end
    tick(2);
    for (int c = 0; c < NUM_CH; c++) begin
      check_ch(c, "rnd_end");
      chk("rnd_steps", 32'(step_cnt[c]), 32'(m_steps[c]));
    end

`ifdef QUAD_INDEX_EN
    // index capture at count 25, then clear drops idx_valid
    pulse_clear(0);
    tick(2);
    for (int k = 0; k < 25; k++) begin set_ab(0, gray(gidx(m_ab[0]) + 1)); tick(8); end
    index[0] = 1'b1; tick(8); index[0] = 1'b0; tick(10);
    chk("idx_count", idx_count[31:0], 32'd25);
    chk("idx_valid", 32'(idx_valid[0]), 32'd1);
    set_ab(0, gray(gidx(m_ab[0]) + 1)); tick(10);
    chk("idx_hold", idx_count[31:0], 32'd25);
    pulse_clear(0);
    tick(1);
    chk("idx_valid_clr", 32'(idx_valid[0]), 32'd0);
    // index rise coincident with clear: capture 0, valid set
    for (int k = 0; k < 3; k++) begin set_ab(0, gray(gidx(m_ab[0]) + 1)); tick(8); end
    chk("idx_pre", cnt_of(0), 32'd3);
    index[0] = 1'b1; tick(6);
    clear[0] = 1'b1; tick(1); clear[0] = 1'b0; m_pos[0] = '0;
    tick(1); index[0] = 1'b0; tick(10);
    chk("idx_clr_count", idx_count[31:0], 32'd0);
    chk("idx_clr_valid", 32'(idx_valid[0]), 32'd1);
    chk("idx_clr_cnt", cnt_of(0), 32'd0);
`endif

    // reset mid-motion with inputs held at 11 through release
    quadA[0] = ~quadA[0];
    tick(3);
    reset = 1'b1;
    quadA = '1; quadB = '1;
    tick(3);
    reset = 1'b0;
    model_reset();
    base = step_cnt[0];
    tick(12);
    chk("prime_steps", 32'(step_cnt[0]), 32'(base));
    for (int c = 0; c < NUM_CH; c++) begin
      check_ch(c, "prime");
    end
    chk("prime_small", 32'(s_count), 32'd0);
    set_ab(0, 2'b01);
    tick(6);
    chk("lat_step6", 32'(step[0]), 32'd0);
    chk("lat_count6", cnt_of(0), 32'd0);
    tick(1);
    chk("lat_step7", 32'(step[0]), 32'd1);
    chk("lat_count7", cnt_of(0), 32'd1);
    tick(6);
    check_ch(0, "final");
    chk("sb_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
